// File: rtl/avg_div_pkg.sv
// Shared types and width helpers for the averaging divider unit.
// Optional rounding is enabled by defining AVG_DIV_ROUND_EN (see avg_div_unit).
package avg_div_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_ACCWIDTH = 32;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Width of a counter that must hold 0..maxValue inclusive (never below 1 bit).
  function automatic int count_width(input int maxValue);
    int w;
    w = clog2(maxValue + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // A restoring divider produces one quotient bit per cycle.
  function automatic int div_cycles(input int accWidth);
    return accWidth;
  endfunction

  localparam int DIV_CYCLES = div_cycles(DEF_ACCWIDTH);

endpackage

// File: rtl/avg_div_unit_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// The dividend is shifted out of the quotient register while the quotient
// bits are shifted in, so a single register serves both roles.
module seq_divider
  import avg_div_pkg::*;
#(
  parameter int ACCWIDTH = DEF_ACCWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ACCWIDTH-1:0] dividend,
  input  logic [ACCWIDTH-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [ACCWIDTH-1:0] quotient
);

  localparam int Cycles = div_cycles(ACCWIDTH);
  localparam int CntW   = count_width(Cycles);

  logic                busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ACCWIDTH-1:0] quot_q, quot_d;
  logic [ACCWIDTH-1:0] rem_q, rem_d;
  logic [ACCWIDTH-1:0] divisor_q, divisor_d;

  logic [ACCWIDTH:0]   shifted;
  logic                fits;
  logic [ACCWIDTH-1:0] remNext;
  logic [ACCWIDTH-1:0] quotNext;

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  always_comb begin
    shifted  = {rem_q, quot_q[ACCWIDTH-1]};
    fits     = (shifted >= {1'b0, divisor_q});
    remNext  = fits ? (shifted[ACCWIDTH-1:0] - divisor_q) : shifted[ACCWIDTH-1:0];
    quotNext = {quot_q[ACCWIDTH-2:0], fits};
  end

  // Load on start, otherwise iterate while busy and stop after the last bit.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    if (start) begin
      busy_d    = 1'b1;
      cnt_d     = CntW'(Cycles);
      quot_d    = dividend;
      rem_d     = '0;
      divisor_d = divisor;
    end else if (busy_q) begin
      quot_d = quotNext;
      rem_d  = remNext;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) busy_d = 1'b0;
    end
  end

  // Divider state registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CntW'(1));
  assign quotient = quot_q;

endmodule

// File: rtl/avg_div_unit.sv
// Averaging engine: accumulates a batch of samples over valid/ready, divides
// the sum by the sample count or an external divisor, and returns a saturated
// quotient over valid/ready.
// Define AVG_DIV_ROUND_EN for round-to-nearest (ties away from zero);
// the default build truncates.
module avg_div_unit
  import avg_div_pkg::*;
#(
  parameter int DATAWIDTH   = 16,
  parameter int ACCWIDTH    = 32,
  parameter int MAX_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_last,
  input  logic                 mode,
  input  logic [DATAWIDTH-1:0] num,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 ovf,
  output logic                 dbz
);

  localparam int CntW = count_width(MAX_SAMPLES);

  state_e              state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                dbz_q, dbz_d;
  logic                round_ovf_q, round_ovf_d;

  logic                accept;
  logic [ACCWIDTH-1:0] accSum;
  logic [CntW-1:0]     countInc;
  logic                closeBatch;
  logic [ACCWIDTH-1:0] divisorSel;
  logic                divisorZero;
  logic [ACCWIDTH-1:0] dividend;
  logic                roundOvf;
  logic                divStart;
  logic                divBusy;
  logic                divDone;
  logic [ACCWIDTH-1:0] quotient;
  logic                quotHigh;
  logic                ovfRaw;

  // Candidate values for the sample being offered; the batch closes on an
  // explicit last or when this sample fills the batch, whichever comes first.
  always_comb begin
    accept      = in_valid && (state_q == ACCUM);
    accSum      = acc_q + ACCWIDTH'(in_data);
    countInc    = count_q + 1'b1;
    closeBatch  = in_last || (countInc == CntW'(MAX_SAMPLES));
    divisorSel  = mode ? ACCWIDTH'(num) : ACCWIDTH'(countInc);
    divisorZero = (divisorSel == '0);
  end

`ifdef AVG_DIV_ROUND_EN
  logic [ACCWIDTH:0] roundSum;

  // Bias the dividend by half the divisor; a carry out means the sum no longer fits.
  always_comb begin
    roundSum = {1'b0, accSum} + {2'b00, divisorSel[ACCWIDTH-1:1]};
    dividend = roundSum[ACCWIDTH-1:0];
    roundOvf = roundSum[ACCWIDTH];
  end
`else
  // Truncating division uses the raw sum.
  always_comb begin
    dividend = accSum;
    roundOvf = 1'b0;
  end
`endif

  assign divStart = accept && closeBatch && !divisorZero;

  seq_divider #(
    .ACCWIDTH(ACCWIDTH)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (divStart),
    .dividend (dividend),
    .divisor  (divisorSel),
    .busy     (divBusy),
    .done     (divDone),
    .quotient (quotient)
  );

  // Next-state logic: accumulate, wait for the divider, then hold the result.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    dbz_d       = dbz_q;
    round_ovf_d = round_ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d   = accSum;
          count_d = countInc;
          if (closeBatch) begin
            dbz_d       = divisorZero;
            round_ovf_d = roundOvf;
            state_d     = divisorZero ? DONE : DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (divDone || !divBusy) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d     = ACCUM;
          acc_d       = '0;
          count_d     = '0;
          dbz_d       = 1'b0;
          round_ovf_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulator and result-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      dbz_q       <= 1'b0;
      round_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      dbz_q       <= dbz_d;
      round_ovf_q <= round_ovf_d;
    end
  end

  // Saturate the wide quotient into the output width; outputs read zero outside DONE.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    quotHigh  = ((quotient >> DATAWIDTH) != '0);
    ovfRaw    = !dbz_q && (quotHigh || round_ovf_q);
    out_data  = '0;
    if (out_valid) begin
      out_data = (dbz_q || ovfRaw) ? '1 : quotient[DATAWIDTH-1:0];
    end
    ovf = out_valid && ovfRaw;
    dbz = out_valid && dbz_q;
  end

endmodule
